pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses into human-visible LED blinks, one blink per event.
- Sits downstream of the button edge/debounce pulse generators and drives board LEDs or other slow indicators.
- Queues events that arrive during a blink in a saturating pending counter, so bursts are not silently lost.

Parameters:
- HOLD_CYCLES, 25_000_000: cycles led_out stays high per blink (>=1).
- GAP_CYCLES, 12_500_000: cycles led_out stays low between consecutive blinks (>=1).
- PEND_W, 4: width of the pending-event counter; saturates at 2^PEND_W-1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- pulse_in  input  1  event strobe; each cycle sampled high is one event.
- led_out  output  1  stretched blink output, registered.
- busy  output  1  high whenever state is not IDLE.
- pending  output  PEND_W  queued events not yet started.
- overflow  output  1  one-cycle strobe when an event is dropped at saturation.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, led_out=0, busy=0, pending=0, overflow=0, timer=0. Effect is immediate, with no clock edge needed. Reset mid-blink discards the blink and all pending events.
- States: IDLE, ON, GAP. Timer width is $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
- Event available = pulse_in OR (pending != 0).
- IDLE: if an event is available at edge k, go to ON. led_out=1 from cycle k+1 (latency 1). Load the timer.
- ON: led_out=1 for exactly HOLD_CYCLES cycles, then GAP.
- GAP: led_out=0 for exactly GAP_CYCLES cycles. On the last GAP cycle, go to ON if an event is available, else IDLE. There is no IDLE bubble, so the blink period under backlog is exactly HOLD_CYCLES+GAP_CYCLES.
- Consume: one event is consumed on each IDLE->ON or GAP->ON transition. A live pulse_in is used first; otherwise pending is decremented.
- Pending update: pending_next = pending + pulse_in − consume_from_pending, where pulse_in is counted only if not directly consumed.
  - Simultaneous pulse_in with a pending consume leaves pending unchanged.
- Saturation: an arriving pulse_in that would push pending above 2^PEND_W-1 is dropped. overflow=1 for that single cycle (registered, next cycle); pending is held at max.
- pulse_in held high N cycles counts as N events; no edge detection here.
- busy is a decode of the state register: ~(state==IDLE).
- pending changes only on clock edges; it is never negative and never wraps.

Decomposition:
- No shared package. State encoding (IDLE=2'd0, ON=2'd1, GAP=2'd2) as localparams in the module.
- One natural sub-module: sat_updown_counter (params W).
  - Inputs: inc, dec.
  - Outputs: count, sat_drop.
  - Holds on inc&dec; saturates at 0 and 2^W-1.
  - The timer stays inline.

Test Plan (overrides HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2; cycle n = nth rising edge after reset release):
- Single pulse at cycle 10 -> led_out=1 cycles 11–14, 0 from 15; busy=1 cycles 11–16, 0 at 17; pending stays 0; overflow never 1.
- Pulses at cycles 10,11,12 -> led_out high 11–14, 17–20, 23–26; pending 1 at 12, 2 at 13, 1 at 17, 0 at 23; busy continuous 11–28.
- Pulses every cycle 10–14 (5 events) -> pending reaches 3 at 14; overflow=1 only in cycle 15; exactly four blinks (ON starting 11, 17, 23, 29); pending 0 after cycle 29.
- Single pulse at cycle 10, second pulse at cycle 16 (last GAP cycle) -> ON continues directly at 17 (led_out 17–20); pending never leaves 0; busy never drops between 11 and 22.
- Pulses at 10,11,12, then reset=0 asynchronously mid-cycle 13 -> led_out, busy, pending, overflow read 0 before the next edge. After release with pulse_in=0, no further blinks for 50 cycles.
- pulse_in held high cycles 10–12 (3-cycle level) -> identical response to the three-pulse scenario: three blinks.

Source files
------------

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// rtl/pulse_stretcher_sat_updown_counter.sv - saturating up/down event counter
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_drop
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic up_only;
  logic down_only;

  assign up_only   = inc & ~dec;
  assign down_only = dec & ~inc;

  // An increment that cannot be stored is reported so the caller can flag it.
  assign sat_drop  = up_only & (count == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (up_only && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end else if (down_only && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - one visible blink per event pulse, with queued backlog
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          ev_avail;
  logic          consume;
  logic          cnt_inc;
  logic          cnt_dec;
  logic          sat_drop;

  assign ev_avail = pulse_in | (pending != '0);

  // A live pulse is spent first; only without one does the backlog shrink.
  assign cnt_inc  = pulse_in & ~consume;
  assign cnt_dec  = consume & ~pulse_in;

  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    timer_next = timer;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (ev_avail) begin
          state_next = ON;
          timer_next = HOLD_LOAD;
          consume    = 1'b1;
        end
      end
      ON: begin
        if (timer == '0) begin
          state_next = GAP;
          timer_next = GAP_LOAD;
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      GAP: begin
        // Chaining straight into ON keeps the backlog period at HOLD+GAP.
        if (timer == '0) begin
          if (ev_avail) begin
            state_next = ON;
            timer_next = HOLD_LOAD;
            consume    = 1'b1;
          end else begin
            state_next = IDLE;
            timer_next = '0;
          end
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      led_out  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      led_out  <= (state_next == ON);
      overflow <= sat_drop;
    end
  end

  sat_updown_counter #(
    .W(PEND_W)
  ) u_pend_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .count    (pending),
    .sat_drop (sat_drop)
  );

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench for pulse_stretcher
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pulse_in = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  typedef struct {
    logic led;
    logic busy;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc;
  logic led_at[128];
  logic busy_at[128];
  logic ovf_at[128];
  int   pend_at[128];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Reference: a blink started at edge s lights cycles s+1..s+H and blocks new
  // starts until edge s+H+G; events that cannot start immediately are queued.
  initial begin
    int   m_t, m_pend, m_ready, m_last;
    exp_t e;
    m_t = 0; m_pend = 0; m_ready = 0; m_last = -100;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_t = 0; m_pend = 0; m_ready = 0; m_last = -100;
      end else begin
        m_t++;
        e.ovf = 1'b0;
        if (m_t >= m_ready && (pulse_in || m_pend > 0)) begin
          if (!pulse_in) m_pend--;
          m_last  = m_t;
          m_ready = m_t + H + G;
        end else if (pulse_in) begin
          if (m_pend == PMAX) e.ovf = 1'b1;
          else m_pend++;
        end
        e.led  = (m_t - m_last) < H;
        e.busy = m_t < m_ready;
        e.pend = m_pend;
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("led_out", int'(led_out), int'(e.led));
        chk("busy", int'(busy), int'(e.busy));
        chk("pending", int'(pending), e.pend);
        chk("overflow", int'(overflow), int'(e.ovf));
      end
      if (reset && cyc + 1 < 128) begin
        led_at[cyc+1]  = led_out;
        busy_at[cyc+1] = busy;
        ovf_at[cyc+1]  = overflow;
        pend_at[cyc+1] = int'(pending);
      end
    end
  end

  task automatic clear_hist();
    for (int i = 0; i < 128; i++) begin
      led_at[i] = 1'b0; busy_at[i] = 1'b0; ovf_at[i] = 1'b0; pend_at[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pulse_in = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    clear_hist();
    reset = 1'b1;
  endtask

  // Bit n of mask drives pulse_in so that rising edge n samples it.
  task automatic run_mask(input logic [63:0] mask, input int len);
    for (int n = 1; n <= len; n++) begin
      pulse_in = mask[n];
      @(posedge clk);
      #1;
    end
    pulse_in = 1'b0;
  endtask

  function automatic int count_blinks(input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) if (led_at[n] && !led_at[n-1]) c++;
    return c;
  endfunction

  function automatic int all_busy(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) if (!busy_at[n]) return 0;
    return 1;
  endfunction

  initial begin
    logic [63:0] m;
    int          ovf_cnt;
    int          dens;

    @(posedge clk);
    #1;
    chk("rst_led", int'(led_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);

    // single pulse
    do_reset();
    m = 64'd1 << 10;
    run_mask(m, 40);
    chk("s1_led10", int'(led_at[10]), 0);
    chk("s1_led11", int'(led_at[11]), 1);
    chk("s1_led14", int'(led_at[14]), 1);
    chk("s1_led15", int'(led_at[15]), 0);
    chk("s1_busy16", int'(busy_at[16]), 1);
    chk("s1_busy17", int'(busy_at[17]), 0);
    chk("s1_blinks", count_blinks(1, 40), 1);

    // three consecutive pulses (also the 3-cycle level case)
    do_reset();
    m = (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12);
    run_mask(m, 45);
    chk("s2_pend12", pend_at[12], 1);
    chk("s2_pend13", pend_at[13], 2);
    chk("s2_pend17", pend_at[17], 1);
    chk("s2_pend23", pend_at[23], 0);
    chk("s2_led17", int'(led_at[17]), 1);
    chk("s2_led23", int'(led_at[23]), 1);
    chk("s2_led27", int'(led_at[27]), 0);
    chk("s2_busy_run", all_busy(11, 28), 1);
    chk("s2_busy29", int'(busy_at[29]), 0);
    chk("s2_blinks", count_blinks(1, 45), 3);

    // five pulses, backlog saturates
    do_reset();
    m = 64'h1f << 10;
    run_mask(m, 50);
    chk("s3_pend14", pend_at[14], 3);
    chk("s3_ovf14", int'(ovf_at[14]), 0);
    chk("s3_ovf15", int'(ovf_at[15]), 1);
    chk("s3_ovf16", int'(ovf_at[16]), 0);
    chk("s3_led29", int'(led_at[29]), 1);
    chk("s3_pend30", pend_at[30], 0);
    chk("s3_blinks", count_blinks(1, 50), 4);

    // second pulse on the last gap cycle chains directly
    do_reset();
    m = (64'd1 << 10) | (64'd1 << 16);
    run_mask(m, 40);
    chk("s4_led17", int'(led_at[17]), 1);
    chk("s4_led20", int'(led_at[20]), 1);
    chk("s4_pend17", pend_at[17], 0);
    chk("s4_busy_run", all_busy(11, 22), 1);
    chk("s4_blinks", count_blinks(1, 40), 2);

    // asynchronous reset mid-blink with backlog
    do_reset();
    m = (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12);
    run_mask(m, 12);
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("s5_led", int'(led_out), 0);
    chk("s5_busy", int'(busy), 0);
    chk("s5_pending", int'(pending), 0);
    chk("s5_overflow", int'(overflow), 0);
    do_reset();
    run_mask(64'd0, 50);
    chk("s5_no_blinks", count_blinks(1, 50), 0);

    // randomized traffic of varying density
    do_reset();
    ovf_cnt = 0;
    for (int seg = 0; seg < 15; seg++) begin
      dens = int'($urandom_range(0, 100));
      for (int n = 0; n < 200; n++) begin
        pulse_in = ($urandom_range(0, 99) < dens);
        @(posedge clk);
        #1;
        if (overflow) ovf_cnt++;
      end
    end
    pulse_in = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rand_drain_busy", int'(busy), 0);
    chk("rand_drain_pending", int'(pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
